// File: rtl/video_pkg.sv
// Shared types and constants for the video timing / test-pattern generator:
// pattern mode encodings, the RGB888 pixel type and the colour-bar palette.
package video_pkg;

    typedef logic [23:0] rgb_t;

    typedef enum logic [1:0] {
        MODE_BARS  = 2'd0,
        MODE_GRAD  = 2'd1,
        MODE_CHK   = 2'd2,
        MODE_SOLID = 2'd3
    } mode_e;

    localparam rgb_t BAR_WHITE   = 24'hFFFFFF;
    localparam rgb_t BAR_YELLOW  = 24'hFFFF00;
    localparam rgb_t BAR_CYAN    = 24'h00FFFF;
    localparam rgb_t BAR_GREEN   = 24'h00FF00;
    localparam rgb_t BAR_MAGENTA = 24'hFF00FF;
    localparam rgb_t BAR_RED     = 24'hFF0000;
    localparam rgb_t BAR_BLUE    = 24'h0000FF;
    localparam rgb_t BAR_BLACK   = 24'h000000;

    // Bar index 0 is the leftmost bar.
    function automatic rgb_t bar_colour(input logic [2:0] idx);
        rgb_t c;
        case (idx)
            3'd0:    c = BAR_WHITE;
            3'd1:    c = BAR_YELLOW;
            3'd2:    c = BAR_CYAN;
            3'd3:    c = BAR_GREEN;
            3'd4:    c = BAR_MAGENTA;
            3'd5:    c = BAR_RED;
            3'd6:    c = BAR_BLUE;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/video_timing_core.sv
// Horizontal/vertical raster counters, completed-frame counter and the
// unregistered de/hs/vs decode of the current counter position.
module video_timing_core #(
    parameter int H_ACT  = 64,
    parameter int H_FP   = 8,
    parameter int H_SYNC = 2,
    parameter int H_BP   = 8,
    parameter int V_ACT  = 64,
    parameter int V_FP   = 8,
    parameter int V_SYNC = 4,
    parameter int V_BP   = 8,
    parameter bit HS_POL = 1'b0,
    parameter bit VS_POL = 1'b0,
    parameter int CW     = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    output logic [CW-1:0] hcnt,
    output logic [CW-1:0] vcnt,
    output logic          line_end,
    output logic          frame_start,
    output logic          de,
    output logic          hs,
    output logic          vs,
    output logic [15:0]   frame_cnt
);

    localparam logic [CW-1:0] H_ACT_C = CW'(H_ACT);
    localparam logic [CW-1:0] HS_BEG  = CW'(H_ACT + H_FP);
    localparam logic [CW-1:0] HS_END  = CW'(H_ACT + H_FP + H_SYNC);
    localparam logic [CW-1:0] H_LAST  = CW'(H_ACT + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CW-1:0] V_ACT_C = CW'(V_ACT);
    localparam logic [CW-1:0] VS_BEG  = CW'(V_ACT + V_FP);
    localparam logic [CW-1:0] VS_END  = CW'(V_ACT + V_FP + V_SYNC);
    localparam logic [CW-1:0] V_LAST  = CW'(V_ACT + V_FP + V_SYNC + V_BP - 1);

    logic [CW-1:0] hcnt_q, hcnt_d;
    logic [CW-1:0] vcnt_q, vcnt_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic          frame_end;
    logic          hs_act, vs_act;

    always_comb begin
        hcnt_d      = hcnt_q;
        vcnt_d      = vcnt_q;
        frame_cnt_d = frame_cnt_q;
        line_end    = (hcnt_q == H_LAST);
        frame_end   = line_end && (vcnt_q == V_LAST);
        if (ce) begin
            hcnt_d = line_end ? '0 : hcnt_q + CW'(1);
            if (line_end) begin
                vcnt_d = frame_end ? '0 : vcnt_q + CW'(1);
            end
            // Natural 16-bit wrap gives 65535 -> 0.
            if (frame_end) begin
                frame_cnt_d = frame_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            frame_cnt_q <= '0;
        end else begin
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // vs depends on vcnt only, so it switches with the line boundary at hcnt=0.
    always_comb begin
        de          = (hcnt_q < H_ACT_C) && (vcnt_q < V_ACT_C);
        hs_act      = (hcnt_q >= HS_BEG) && (hcnt_q < HS_END);
        vs_act      = (vcnt_q >= VS_BEG) && (vcnt_q < VS_END);
        hs          = HS_POL ? hs_act : !hs_act;
        vs          = VS_POL ? vs_act : !vs_act;
        frame_start = (hcnt_q == '0) && (vcnt_q == '0);
    end

    assign hcnt      = hcnt_q;
    assign vcnt      = vcnt_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: rtl/video_pattern_gen.sv
// Video timing and test-pattern generator: mode shadow register, pattern
// mux and the output register stage (one ce-cycle behind the counters).
module video_pattern_gen
    import video_pkg::*;
#(
    parameter int H_ACT    = 64,
    parameter int H_FP     = 8,
    parameter int H_SYNC   = 2,
    parameter int H_BP     = 8,
    parameter int V_ACT    = 64,
    parameter int V_FP     = 8,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 8,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = 11,
    parameter int CHK_LOG2 = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    input  logic [1:0]    mode,
    input  logic [23:0]   solid_rgb,
    output logic          de,
    output logic          hs,
    output logic          vs,
    output logic [7:0]    r,
    output logic [7:0]    g,
    output logic [7:0]    b,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          sof,
    output logic [15:0]   frame_cnt
);

    localparam int BAR_W = H_ACT / 8;
    localparam int BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

    logic [CW-1:0] hcnt, vcnt;
    logic          line_end, frame_start;
    logic          de_c, hs_c, vs_c;
    logic [15:0]   fcnt_c;

    video_timing_core #(
        .H_ACT(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACT(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HS_POL(HS_POL), .VS_POL(VS_POL), .CW(CW)
    ) u_timing (
        .clk(clk), .rst(rst), .ce(ce),
        .hcnt(hcnt), .vcnt(vcnt),
        .line_end(line_end), .frame_start(frame_start),
        .de(de_c), .hs(hs_c), .vs(vs_c),
        .frame_cnt(fcnt_c)
    );

    mode_e         mode_q, mode_d, mode_eff;
    rgb_t          solid_q, solid_d, solid_eff;
    logic [BW-1:0] bar_pix_q, bar_pix_d;
    logic [2:0]    bar_idx_q, bar_idx_d;
    rgb_t          pix;

    logic          de_q, de_d, hs_q, hs_d, vs_q, vs_d, sof_q, sof_d;
    rgb_t          rgb_q, rgb_d;
    logic [CW-1:0] x_q, x_d, y_q, y_d;
    logic [15:0]   fcnt_q, fcnt_d;

    // The shadow loads at (0,0); bypassing it there lets the new mode cover that pixel too.
    always_comb begin
        mode_eff  = frame_start ? mode_e'(mode) : mode_q;
        solid_eff = frame_start ? solid_rgb     : solid_q;
        mode_d    = mode_q;
        solid_d   = solid_q;
        if (ce && frame_start) begin
            mode_d  = mode_eff;
            solid_d = solid_eff;
        end
    end

    // Bar position tracks hcnt with a small counter instead of dividing.
    always_comb begin
        bar_pix_d = bar_pix_q;
        bar_idx_d = bar_idx_q;
        if (ce) begin
            if (line_end) begin
                bar_pix_d = '0;
                bar_idx_d = '0;
            end else if (bar_pix_q == BAR_LAST) begin
                bar_pix_d = '0;
                bar_idx_d = bar_idx_q + 3'd1;
            end else begin
                bar_pix_d = bar_pix_q + BW'(1);
            end
        end
    end

    always_comb begin
        case (mode_eff)
            MODE_BARS: pix = bar_colour(bar_idx_q);
            MODE_GRAD: pix = {hcnt[7:0], hcnt[7:0], hcnt[7:0]};
            MODE_CHK:  pix = (hcnt[CHK_LOG2] ^ vcnt[CHK_LOG2]) ? BAR_WHITE : BAR_BLACK;
            default:   pix = solid_eff;
        endcase
        if (!de_c) begin
            pix = '0;
        end
    end

    always_comb begin
        de_d   = de_q;
        hs_d   = hs_q;
        vs_d   = vs_q;
        sof_d  = sof_q;
        rgb_d  = rgb_q;
        x_d    = x_q;
        y_d    = y_q;
        fcnt_d = fcnt_q;
        if (ce) begin
            de_d   = de_c;
            hs_d   = hs_c;
            vs_d   = vs_c;
            sof_d  = frame_start;
            rgb_d  = pix;
            x_d    = de_c ? hcnt : '0;
            y_d    = de_c ? vcnt : '0;
            fcnt_d = fcnt_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q    <= MODE_BARS;
            solid_q   <= '0;
            bar_pix_q <= '0;
            bar_idx_q <= '0;
            de_q      <= 1'b0;
            hs_q      <= !HS_POL;
            vs_q      <= !VS_POL;
            sof_q     <= 1'b0;
            rgb_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            fcnt_q    <= '0;
        end else begin
            mode_q    <= mode_d;
            solid_q   <= solid_d;
            bar_pix_q <= bar_pix_d;
            bar_idx_q <= bar_idx_d;
            de_q      <= de_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            sof_q     <= sof_d;
            rgb_q     <= rgb_d;
            x_q       <= x_d;
            y_q       <= y_d;
            fcnt_q    <= fcnt_d;
        end
    end

    assign de        = de_q;
    assign hs        = hs_q;
    assign vs        = vs_q;
    assign sof       = sof_q;
    assign r         = rgb_q[23:16];
    assign g         = rgb_q[15:8];
    assign b         = rgb_q[7:0];
    assign x         = x_q;
    assign y         = y_q;
    assign frame_cnt = fcnt_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Scoreboard bench for video_pattern_gen: a raster model indexed by the
// count of ce cycles since reset predicts every output sample.
module tb_video_pattern_gen;

    localparam int H_ACT = 64, H_FP = 8, H_SYNC = 2, H_BP = 8;
    localparam int V_ACT = 64, V_FP = 8, V_SYNC = 4, V_BP = 8;
    localparam int CW = 11;
    localparam bit HS_POL = 1'b0, VS_POL = 1'b0;
    localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
    localparam int FT    = H_TOT * V_TOT;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ce = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [23:0]   solid_rgb = 24'h0;
    logic          de, hs, vs, sof;
    logic [7:0]    r, g, b;
    logic [CW-1:0] x, y;
    logic [15:0]   frame_cnt;

    video_pattern_gen dut (
        .clk(clk), .rst(rst), .ce(ce), .mode(mode), .solid_rgb(solid_rgb),
        .de(de), .hs(hs), .vs(vs), .r(r), .g(g), .b(b),
        .x(x), .y(y), .sof(sof), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        de, hs, vs, sof;
        logic [23:0] rgb;
        int          x, y;
        int          fc;
    } exp_t;

    exp_t        q[$];
    exp_t        reset_exp;
    int          errors = 0;
    int          checks = 0;
    int          k = 0;
    int          m_mode = 0;
    logic [23:0] m_solid = 24'h0;
    logic [23:0] bars[8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic cmp(input exp_t e);
        chk("de", int'(de), int'(e.de));
        chk("hs", int'(hs), int'(e.hs));
        chk("vs", int'(vs), int'(e.vs));
        chk("sof", int'(sof), int'(e.sof));
        chk("rgb", int'({r, g, b}), int'(e.rgb));
        chk("frame_cnt", int'(frame_cnt), e.fc);
        if (e.de) begin
            chk("x", int'(x), e.x);
            chk("y", int'(y), e.y);
        end
    endtask

    // Expected outputs after the ce edge taken at raster position index kk.
    function automatic exp_t model(input int kk);
        exp_t e;
        int hc, vc;
        hc    = kk % H_TOT;
        vc    = (kk / H_TOT) % V_TOT;
        e.de  = (hc < H_ACT) && (vc < V_ACT);
        e.hs  = (hc >= H_ACT + H_FP && hc < H_ACT + H_FP + H_SYNC) ? HS_POL : !HS_POL;
        e.vs  = (vc >= V_ACT + V_FP && vc < V_ACT + V_FP + V_SYNC) ? VS_POL : !VS_POL;
        e.sof = (hc == 0) && (vc == 0);
        e.x   = hc;
        e.y   = vc;
        e.fc  = (kk / FT) % 65536;
        if (!e.de)             e.rgb = 24'h0;
        else if (m_mode == 0)  e.rgb = bars[hc / (H_ACT / 8)];
        else if (m_mode == 1)  e.rgb = {3{8'(hc % 256)}};
        else if (m_mode == 2)  e.rgb = ((((hc >> 3) ^ (vc >> 3)) & 1) == 1) ? 24'hFFFFFF : 24'h0;
        else                   e.rgb = m_solid;
        return e;
    endfunction

    task automatic step(input int pce, input int md, input logic [23:0] sd);
        @(negedge clk);
        mode      = 2'(md);
        solid_rgb = sd;
        ce        = ($urandom_range(99) < pce);
        if (ce) begin
            if ((k % FT) == 0) begin
                m_mode  = md;
                m_solid = sd;
            end
            q.push_back(model(k));
            k++;
        end
    endtask

    task automatic check_reset_values();
        chk("rst_de", int'(de), 0);
        chk("rst_sof", int'(sof), 0);
        chk("rst_hs", int'(hs), int'(!HS_POL));
        chk("rst_vs", int'(vs), int'(!VS_POL));
        chk("rst_rgb", int'({r, g, b}), 0);
        chk("rst_x", int'(x), 0);
        chk("rst_y", int'(y), 0);
        chk("rst_frame_cnt", int'(frame_cnt), 0);
    endtask

    initial begin
        exp_t e, last;
        reset_exp = '{de: 1'b0, hs: !HS_POL, vs: !VS_POL, sof: 1'b0, rgb: 24'h0, x: 0, y: 0, fc: 0};
        last = reset_exp;
        forever begin
            @(posedge clk);
            if (rst) begin
                last = reset_exp;
            end else if (ce) begin
                #1;
                if (q.size() == 0) begin
                    chk("queue_nonempty", 0, 1);
                end else begin
                    e = q.pop_front();
                    cmp(e);
                    last = e;
                end
            end else begin
                #1;
                cmp(last);
            end
        end
    end

    initial begin
        int md;
        repeat (3) @(posedge clk);
        #2;
        check_reset_values();
        @(negedge clk);
        rst = 1'b0;
        ce  = 1'b0;
        k   = 0;

        while (k < 2 * FT + 100)  step(100, 0, 24'h0);
        while (k < 3 * FT + 2000) step(100, 2, 24'h0);
        while (k < 4 * FT + 100)  step(100, 3, 24'h123456);
        while (k < 5 * FT + 10 * H_TOT + 30) step(50, 1, 24'h0);

        @(negedge clk);
        ce = 1'b0;
        #2;
        chk("pre_rst_de", int'(de), 1);
        rst = 1'b1;
        #1;
        check_reset_values();
        ce = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        ce  = 1'b0;
        q.delete();
        k = 0;

        md = $urandom_range(3);
        repeat (3000) step(100, md, 24'($urandom));
        @(negedge clk);
        ce = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
